rg_arb: RTL and testbench
=========================

RG_ARB -- requirements
Module: rg_arb

Interface
REQ-001 Parameter N, default 10: width of the shared register.
REQ-002 Parameter NREQ, default 4: number of requesters; power of two, 2..8.
REQ-003 Parameter HOLD_MAX, default 8: maximum grant length in cycles when the timeout feature is compiled in; range 2..255.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  reset is asynchronous and active-low.
REQ-006 req  input  NREQ  per-requester access request; held high for the whole transaction.
REQ-007 we  input  NREQ  per-requester write enable; acted on only for the current owner.
REQ-008 wdata  input  NREQ*N  packed write data; requester k occupies bits [k*N +: N].
REQ-009 gnt  output  NREQ  one-hot grant, or all zeros.
REQ-010 owner  output  clog2(NREQ)  index of the current or most recent owner.
REQ-011 q  output  N  shared register contents.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 tout  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-014 FSM states: IDLE, GRANT and RELEASE; all outputs are registered.
REQ-015 In IDLE with req==0, the FSM stays in IDLE with gnt=0.
REQ-016 In IDLE with req!=0, at the next edge:
- owner becomes the first set req bit, searching from ptr upward with wrap-around;
- gnt[owner] is set;
- the FSM enters GRANT.
Request-to-grant latency is 1 cycle.
REQ-017 In GRANT, q loads wdata[owner] at each edge where we[owner]=1; we of non-owners is ignored; otherwise q holds.
REQ-018 In GRANT, an edge that samples req[owner]=0 clears gnt, does not write q and enters RELEASE.
REQ-019 RELEASE lasts exactly 1 cycle, with gnt=0 and busy=1; at its end ptr = (owner+1) mod NREQ and the FSM enters IDLE.
REQ-020 The minimum gap between consecutive grants is 2 cycles (RELEASE + IDLE); a requester that stays high is re-served only after all other pending requesters.
REQ-021 req changes by non-owners during GRANT or RELEASE have no effect.
REQ-022 At most one gnt bit is ever set; gnt is never set outside GRANT.

Reset
REQ-023 When reset is low, independent of clk:
- the state becomes IDLE;
- gnt=0, owner=0, q=0, tout=0;
- ptr=0 and the hold counter is 0.
REQ-024 Reset asserted during GRANT aborts the transaction immediately, with no write.
REQ-025 The first arbitration after reset release treats requester 0 as the highest priority.

Configuration
REQ-026 Macro RG_ARB_TIMEOUT_EN enables the hold-limit feature.
REQ-027 With RG_ARB_TIMEOUT_EN defined:
- the hold counter clears on entry to GRANT and increments each GRANT cycle;
- when the counter reaches HOLD_MAX-1 with req[owner] still high, the next edge clears gnt, pulses tout for 1 cycle and enters RELEASE;
- a write with we[owner] on that final edge still takes effect.
REQ-028 Without RG_ARB_TIMEOUT_EN: there is no hold counter, tout is tied to 0, and a grant lasts until req[owner] drops.

Structure
REQ-029 Shared package rg_pkg holds the FSM state encoding (IDLE=0, GRANT=1, RELEASE=2) and the parameter defaults (N, NREQ, HOLD_MAX).
REQ-030 Sub-module rr_pick: a purely combinational round-robin selector (inputs req and ptr; outputs a found flag and an index), instantiated once.
REQ-031 The storage register and the FSM live in rg_arb itself; q has no other writer.

Verification (N=10, NREQ=4, HOLD_MAX=8)
REQ-032 Reset low, then released with req=0 -> gnt=0, q=0, busy=0, owner=0.
REQ-033 req=4'b0010 with we[1]=1, wdata[1]=10'h155 for 3 cycles, then req=0 -> gnt=4'b0010 one cycle after req rises, q=10'h155, then RELEASE, then IDLE.
REQ-034 req=4'b1111 held for 40 cycles, each owner dropping req after 2 grant cycles and raising it again -> grant order 0,1,2,3,0,..., with exactly 2 non-grant cycles between grants.
REQ-035 Owner 2 is granted while we[3]=1, wdata[3]=10'h3FF -> q unchanged.
REQ-036 With the timeout enabled, req[0] held for 20 cycles -> gnt[0] lasts 8 cycles, then tout pulses once and the grant is re-issued after RELEASE+IDLE. With the timeout disabled, the same stimulus -> gnt[0] lasts 20 cycles and tout=0.
REQ-037 Reset pulsed low mid-GRANT between clock edges -> gnt, q and busy go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rg_pkg.sv
// Shared types and parameter defaults for the register arbiter.
// Build option: RG_ARB_TIMEOUT_EN adds a per-grant hold limit.
package rg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam int N_DEF        = 10;
    localparam int NREQ_DEF     = 4;
    localparam int HOLD_MAX_DEF = 8;

endpackage

// File: rtl/rg_arb_if.sv
// Requester-side bundle of the shared register arbiter.
// master drives requests and data, slave is the arbiter.
interface rg_arb_if
    import rg_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int NREQ = NREQ_DEF
);
    localparam int W = $clog2(NREQ);

    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   we;
    logic [NREQ*N-1:0] wdata;
    logic [NREQ-1:0]   gnt;
    logic [W-1:0]      owner;
    logic [N-1:0]      q;
    logic              busy;
    logic              tout;

    modport master (
        output req, we, wdata,
        input  gnt, owner, q, busy, tout
    );

    modport slave (
        input  req, we, wdata,
        output gnt, owner, q, busy, tout
    );
endinterface

// File: rtl/rg_arb_rr_pick.sv
// Combinational round-robin selector: first set req bit
// at or above ptr, wrapping around.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int W    = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [W-1:0]    ptr,
    output logic            found,
    output logic [W-1:0]    idx
);
    logic [W-1:0] c;

    // Scan from the far end so the closest candidate wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        c     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            c = ptr + W'(i);
            if (req[c]) begin
                found = 1'b1;
                idx   = c;
            end
        end
    end
endmodule

// File: rtl/rg_arb.sv
// Round-robin arbiter guarding one shared register.
// Build option: RG_ARB_TIMEOUT_EN limits each grant to HOLD_MAX cycles.
module rg_arb
    import rg_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int NREQ     = NREQ_DEF,
    parameter int HOLD_MAX = HOLD_MAX_DEF
) (
    input logic  clk,
    input logic  reset,
    rg_arb_if.slave bus
);
    localparam int W = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || (NREQ & (NREQ - 1)) != 0) begin : g_bad_nreq
        $error("rg_arb: NREQ must be a power of two in 2..8");
    end
    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold
        $error("rg_arb: HOLD_MAX must be in 2..255");
    end

    state_t          state;
    logic [NREQ-1:0] gnt;
    logic [W-1:0]    owner;
    logic [W-1:0]    ptr;
    logic [N-1:0]    q;
    logic            busy;
    logic            found;
    logic [W-1:0]    pick;
    logic            own_req;
    logic            own_we;
    logic [N-1:0]    wsel;

    assign own_req = bus.req[owner];
    assign own_we  = bus.we[owner];
    assign wsel    = bus.wdata[int'(owner)*N +: N];

    rr_pick #(.NREQ(NREQ), .W(W)) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .found (found),
        .idx   (pick)
    );

`ifdef RG_ARB_TIMEOUT_EN
    localparam logic [7:0] HLAST = 8'(HOLD_MAX - 1);
    logic [7:0] hcnt;
    logic       tout;
    assign bus.tout = tout;
`else
    assign bus.tout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            gnt   <= '0;
            owner <= '0;
            ptr   <= '0;
            q     <= '0;
            busy  <= 1'b0;
`ifdef RG_ARB_TIMEOUT_EN
            hcnt  <= '0;
            tout  <= 1'b0;
`endif
        end else begin
`ifdef RG_ARB_TIMEOUT_EN
            tout <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (found) begin
                        owner <= pick;
                        gnt   <= NREQ'(1) << pick;
                        busy  <= 1'b1;
                        state <= GRANT;
`ifdef RG_ARB_TIMEOUT_EN
                        hcnt  <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (!own_req) begin
                        gnt   <= '0;
                        state <= RELEASE;
                    end else begin
                        if (own_we) begin
                            q <= wsel;
                        end
`ifdef RG_ARB_TIMEOUT_EN
                        // Final write still lands on the revoking edge.
                        if (hcnt == HLAST) begin
                            gnt   <= '0;
                            tout  <= 1'b1;
                            state <= RELEASE;
                        end else begin
                            hcnt <= hcnt + 8'd1;
                        end
`endif
                    end
                end
                RELEASE: begin
                    ptr   <= owner + W'(1);
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt;
    assign bus.owner = owner;
    assign bus.q     = q;
    assign bus.busy  = busy;
endmodule

// File: tb/tb_rg_arb.sv
// Directed bench for rg_arb with a cycle-level reference model.
// Build option: RG_ARB_TIMEOUT_EN selects the hold-limit expectations.
module tb_rg_arb;
    localparam int N        = 10;
    localparam int NREQ     = 4;
    localparam int HOLD_MAX = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    rg_arb_if #(.N(N), .NREQ(NREQ)) bus ();

    rg_arb #(.N(N), .NREQ(NREQ), .HOLD_MAX(HOLD_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: who holds the grant, who held it last, and whether the
    // one-cycle release gap is pending before the next arbitration.
    int         m_own  = -1;
    int         m_last = 0;
    int         m_ptr  = 0;
    int         m_held = 0;
    bit         m_rel  = 1'b0;
    bit         m_tout = 1'b0;
    logic [9:0] m_q    = '0;
    int         mc;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_own  = -1;
            m_last = 0;
            m_ptr  = 0;
            m_held = 0;
            m_rel  = 1'b0;
            m_tout = 1'b0;
            m_q    = '0;
        end else begin
            m_tout = 1'b0;
            if (m_own >= 0) begin
                if (!bus.req[m_own]) begin
                    m_own = -1;
                    m_rel = 1'b1;
                end else begin
                    if (bus.we[m_own])
                        m_q = bus.wdata[m_own*N +: N];
                    m_held++;
`ifdef RG_ARB_TIMEOUT_EN
                    if (m_held == HOLD_MAX) begin
                        m_own  = -1;
                        m_rel  = 1'b1;
                        m_tout = 1'b1;
                    end
`endif
                end
            end else if (m_rel) begin
                m_rel = 1'b0;
                m_ptr = (m_last + 1) % NREQ;
            end else begin
                for (int k = 0; k < NREQ; k++) begin
                    mc = (m_ptr + k) % NREQ;
                    if (bus.req[mc] && m_own < 0) begin
                        m_own  = mc;
                        m_last = mc;
                        m_held = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("gnt", 32'(bus.gnt), (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
        chk("owner", 32'(bus.owner), 32'(m_last));
        chk("q", 32'(bus.q), 32'(m_q));
        chk("busy", 32'(bus.busy), 32'(m_own >= 0 || m_rel));
        chk("tout", 32'(bus.tout), 32'(m_tout));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    int ord[$];
    int gaps[$];
    int gcnt[NREQ];
    int zeros;
    logic [NREQ-1:0] prev;
    int run_len, first_len, runs, touts;
    logic prev0;

    initial begin
        bus.req   = '0;
        bus.we    = '0;
        bus.wdata = '0;

        tick(2);
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_q", 32'(bus.q), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_owner", 32'(bus.owner), 32'd0);
        chk("rst_tout", 32'(bus.tout), 32'd0);
        reset = 1'b1;
        tick(2);
        chk("idle_gnt", 32'(bus.gnt), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Single write by requester 1.
        bus.req = 4'b0010;
        bus.we  = 4'b0010;
        bus.wdata[1*N +: N] = 10'h155;
        tick(1);
        chk("w1_gnt", 32'(bus.gnt), 32'h2);
        chk("w1_owner", 32'(bus.owner), 32'd1);
        chk("w1_busy", 32'(bus.busy), 32'd1);
        tick(1);
        chk("w1_q", 32'(bus.q), 32'h155);
        tick(1);
        bus.req = '0;
        bus.we  = '0;
        tick(1);
        chk("rel_gnt", 32'(bus.gnt), 32'd0);
        chk("rel_busy", 32'(bus.busy), 32'd1);
        tick(1);
        chk("idle2_busy", 32'(bus.busy), 32'd0);
        chk("idle2_q", 32'(bus.q), 32'h155);

        // Owner 2 holds while non-owner 3 asserts we.
        bus.req = 4'b0100;
        bus.we  = 4'b1000;
        bus.wdata[3*N +: N] = 10'h3FF;
        tick(1);
        chk("no_gnt", 32'(bus.gnt), 32'h4);
        tick(3);
        chk("no_q", 32'(bus.q), 32'h155);
        bus.req = '0;
        bus.we  = '0;
        tick(2);

        // Round-robin under full load, fresh from reset.
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        bus.req = 4'b1111;
        prev  = '0;
        zeros = 0;
        for (int k = 0; k < NREQ; k++) gcnt[k] = 0;
        for (int c = 0; c < 40; c++) begin
            tick(1);
            if (bus.gnt != 0 && prev == 0) begin
                ord.push_back(int'(bus.owner));
                gaps.push_back(zeros);
            end
            zeros = (bus.gnt == 0) ? zeros + 1 : 0;
            prev  = bus.gnt;
            for (int k = 0; k < NREQ; k++) begin
                gcnt[k]    = bus.gnt[k] ? gcnt[k] + 1 : 0;
                bus.req[k] = (gcnt[k] < 2);
            end
        end
        chk("rr_count", 32'(ord.size() >= 8), 32'd1);
        for (int i = 0; i < ord.size() && i < 8; i++) begin
            chk("rr_order", 32'(ord[i]), 32'(i % NREQ));
            if (i > 0) chk("rr_gap", 32'(gaps[i]), 32'd2);
        end
        bus.req = '0;
        tick(4);

        // Asynchronous reset in the middle of a grant.
        bus.req = 4'b0001;
        bus.we  = 4'b0001;
        bus.wdata[0 +: N] = 10'h0AA;
        tick(1);
        chk("ar_gnt", 32'(bus.gnt), 32'h1);
        tick(1);
        chk("ar_q", 32'(bus.q), 32'h0AA);
        #1;
        reset = 1'b0;
        #1;
        chk("ar_gnt0", 32'(bus.gnt), 32'd0);
        chk("ar_q0", 32'(bus.q), 32'd0);
        chk("ar_busy0", 32'(bus.busy), 32'd0);
        tick(1);
        reset   = 1'b1;
        bus.req = '0;
        bus.we  = '0;
        tick(2);

        // Long hold by requester 0.
        bus.req   = 4'b0001;
        run_len   = 0;
        first_len = -1;
        runs      = 0;
        touts     = 0;
        prev0     = 1'b0;
        for (int c = 0; c < 24; c++) begin
            tick(1);
            if (bus.gnt[0]) begin
                run_len++;
                if (!prev0) runs++;
            end else if (prev0 && first_len < 0) begin
                first_len = run_len;
            end
            if (!bus.gnt[0]) run_len = 0;
            if (bus.tout) touts++;
            prev0 = bus.gnt[0];
            if (c == 19) bus.req = '0;
        end
`ifdef RG_ARB_TIMEOUT_EN
        chk("hold_len", 32'(first_len), 32'(HOLD_MAX));
        chk("hold_runs", 32'(runs), 32'd2);
        chk("hold_touts", 32'(touts), 32'd2);
`else
        chk("hold_len", 32'(first_len), 32'd20);
        chk("hold_runs", 32'(runs), 32'd1);
        chk("hold_touts", 32'(touts), 32'd0);
`endif
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
